generic_sram_byte_en_arbiter: RTL and testbench
===============================================

# generic_sram_byte_en_arbiter

Shares one single-port byte-enable SRAM between N requesters using round-robin arbitration, with optional burst locking and a bounded hold time. It sits between the SRAM-side ports of several clients (AXI4 SRAM bridges, DMA engines) and one `generic_sram_byte_en_if` SRAM. The SRAM has a fixed one-cycle read latency, and the block routes each read's data-valid back to the requester that issued it.

## Interface
- `N_PORTS`, 2: number of requesters (2..8).
- `MEM_ADDR_BITS`, 10: SRAM word-address width.
- `MEM_DATA_BITS`, 32: SRAM data width; byte enables are `MEM_DATA_BITS/8`.
- `MAX_HOLD`, 16: maximum consecutive locked grants before forced rotation (≥1).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `req`  in  N_PORTS  per-port access request for this cycle.
- `lock`  in  N_PORTS  per-port request to keep ownership after this grant.
- `addr`  in  N_PORTS×MEM_ADDR_BITS  per-port word address.
- `write_en`  in  N_PORTS  per-port: 1 = write, 0 = read.
- `byte_en`  in  N_PORTS×MEM_DATA_BITS/8  per-port byte enables.
- `write_data`  in  N_PORTS×MEM_DATA_BITS  per-port write data.
- `gnt`  out  N_PORTS  one-hot or zero; access performed this cycle.
- `rvalid`  out  N_PORTS  read data valid for that port.
- `rdata`  out  MEM_DATA_BITS  broadcast SRAM read data.
- `sram_if`  generic_sram_byte_en_if.sram_client  the shared SRAM.

## Operation
- Registered state:
  - `owner` (port index).
  - `owner_v` (ownership held).
  - `last` (last granted index).
  - `hold_cnt` (0..MAX_HOLD-1).
  - `rd_port`/`rd_v` (one-deep read-return pipeline).
- States:
  - FREE (`owner_v`=0).
  - OWNED (`owner_v`=1).
- Grant selection (combinational, each cycle):
  - In OWNED with `req[owner]`=1, `owner` is granted unless `hold_cnt`==MAX_HOLD-1 and some other port requests.
  - Otherwise the first requesting port scanning `last+1, last+2, …` modulo N_PORTS is granted; the scan includes `last` itself as the final candidate.
  - No requests means `gnt`=0.
- On a grant to port g:
  - `last`←g.
  - If `lock[g]`: `owner`←g, `owner_v`←1. `hold_cnt`←`hold_cnt`+1 if g was already owner, else 0. If the counter hits MAX_HOLD-1 and no other port requests, it stays at MAX_HOLD-1, so the lone owner is never starved.
  - If `lock[g]`=0: `owner_v`←0, `hold_cnt`←0.
- An owner that deasserts `req` loses ownership: `owner_v`←0 and arbitration goes round-robin in the same cycle.
- SRAM drive:
  - `addr`, `byte_en` and `write_data` are muxed from the granted port.
  - `write_en` = granted & `write_en[g]`.
  - `read_en` = granted & !`write_en[g]`.
  - With no grant: `addr`=0, `write_en`=0, `read_en`=0.
- Read return: a granted read sets `rd_v`←1 and `rd_port`←g. The next cycle `rvalid[rd_port]`=1, and `rdata` = `sram_if.read_data` (passthrough).
- Writes produce no response; a requester treats `gnt` as completion.

## Timing
- Reset (async assert, sync release):
  - Registers: `owner_v`=0, `owner`=0, `last`=N_PORTS-1 (port 0 wins first), `hold_cnt`=0, `rd_v`=0.
  - Outputs: `gnt`=0 whenever `req`=0, `rvalid`=0.
- `gnt` is combinational from `req`/`lock` and state, valid in the same cycle. Requesters must hold `req` and the access fields stable until `gnt`.
- Read latency: `rvalid` follows the read's `gnt` cycle by exactly 1. Back-to-back reads from different ports return in issue order, one per cycle.
- Throughput: one access per cycle, with no bubble between ports.
- Reset mid-burst drops ownership and discards any pending `rvalid`.
- Simultaneous events:
  - A `req` fall and another port's `req` rise in the same cycle: the new port is granted that cycle.
  - A write immediately after a read on the same address: the read returns the old data.

## Structure
- Package `generic_sram_arb_pkg`: `port_idx_t` width function `$clog2(N_PORTS)` helper and the `arb_state_e` {FREE, OWNED} enum.
- Sub-module `sram_arb_rr_pick`: combinational round-robin picker (`req`, `last` → one-hot `gnt`, index, `any`), reused by other arbiters.

## Test plan
- Reset, then ports 0 and 1 request simultaneously every cycle with `lock`=0 → grants alternate 0,1,0,1; the first grant goes to port 0.
- Port 1 writes 0xDEADBEEF to addr 0x10 with `byte_en`=0xF; port 0 then reads 0x10 → `rvalid[0]` one cycle after `gnt[0]`, `rdata`=0xDEADBEEF.
- Partial write:
  - Port 0 writes 0x000000AA with `byte_en`=0x1 over 0x11223344.
  - Port 0 then reads the same address → `rdata` = 0x112233AA.
- Burst lock:
  - Port 0 holds `req`+`lock` with MAX_HOLD=4, and port 1 requests continuously.
  - Required: port 0 gets 4 consecutive grants, then port 1 is granted. With port 1 idle, port 0 keeps the grant indefinitely.
- Mid-read reset: `rst_n` asserted in the cycle after a read `gnt` → `rvalid`=0 immediately. After release, port 0 is granted first.
- Interleaved reads by ports 0,1,0 on consecutive cycles to addresses 1,2,3 → `rvalid` one-hot sequence 0,1,0 with matching data, no gaps.

Source files
------------

// File: rtl/generic_sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiters.
package generic_sram_arb_pkg;

  typedef enum logic {
    FREE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Width of a port index; a single port still needs one bit.
  function automatic int unsigned port_idx_bits(input int unsigned n_ports);
    return (n_ports > 1) ? $clog2(n_ports) : 1;
  endfunction

endpackage

// File: rtl/generic_sram_byte_en_if.sv
// Single-port byte-enable SRAM bus with a fixed one-cycle read latency.
interface generic_sram_byte_en_if #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BITS = 32
);
  logic [ADDR_BITS-1:0]   addr;
  logic                   read_en;
  logic                   write_en;
  logic [DATA_BITS/8-1:0] byte_en;
  logic [DATA_BITS-1:0]   write_data;
  logic [DATA_BITS-1:0]   read_data;

  modport sram_client (
    output addr, read_en, write_en, byte_en, write_data,
    input  read_data
  );

  modport sram (
    input  addr, read_en, write_en, byte_en, write_data,
    output read_data
  );
endinterface

// File: rtl/sram_arb_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, last_i itself last.
module sram_arb_rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 1; k <= int'(N); k++) begin
      j = (int'(last_i) + k) % int'(N);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/generic_sram_byte_en_arbiter.sv
// Round-robin arbiter sharing one byte-enable SRAM between N_PORTS requesters,
// with burst locking bounded by MAX_HOLD and one-deep read-return routing.
module generic_sram_byte_en_arbiter
  import generic_sram_arb_pkg::*;
#(
  parameter int unsigned N_PORTS       = 2,
  parameter int unsigned MEM_ADDR_BITS = 10,
  parameter int unsigned MEM_DATA_BITS = 32,
  parameter int unsigned MAX_HOLD      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_PORTS-1:0]                   req_i,
  input  logic [N_PORTS-1:0]                   lock_i,
  input  logic [N_PORTS*MEM_ADDR_BITS-1:0]     addr_i,
  input  logic [N_PORTS-1:0]                   write_en_i,
  input  logic [N_PORTS*(MEM_DATA_BITS/8)-1:0] byte_en_i,
  input  logic [N_PORTS*MEM_DATA_BITS-1:0]     write_data_i,
  output logic [N_PORTS-1:0]                   gnt_o,
  output logic [N_PORTS-1:0]                   rvalid_o,
  output logic [MEM_DATA_BITS-1:0]             rdata_o,
  generic_sram_byte_en_if.sram_client          sram_if
);

  localparam int unsigned IW = port_idx_bits(N_PORTS);
  localparam int unsigned BW = MEM_DATA_BITS / 8;
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [IW-1:0] rd_port_q, rd_port_d;
  logic          rd_v_q, rd_v_d;

  logic [N_PORTS-1:0] rr_gnt;
  logic [IW-1:0]      rr_idx;
  logic               rr_any;
  logic [N_PORTS-1:0] owner_oh;
  logic               others_req;
  logic               hold_max;
  logic               keep_owner;
  logic [IW-1:0]      g_idx;
  logic               g_any;
  logic               g_we;

  sram_arb_rr_pick #(.N(N_PORTS), .IW(IW)) u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .gnt_o  (rr_gnt),
    .idx_o  (rr_idx),
    .any_o  (rr_any)
  );

  // Owner keeps the SRAM unless its hold budget is spent while someone else waits.
  assign owner_oh   = N_PORTS'(1) << owner_q;
  assign others_req = |(req_i & ~owner_oh);
  assign hold_max   = (hold_q == HW'(MAX_HOLD - 1));
  assign keep_owner = (state_q == OWNED) && req_i[owner_q] && !(hold_max && others_req);

  assign gnt_o = keep_owner ? owner_oh : rr_gnt;
  assign g_idx = keep_owner ? owner_q : rr_idx;
  assign g_any = keep_owner | rr_any;
  assign g_we  = write_en_i[g_idx];

  assign sram_if.addr       = g_any ? addr_i[g_idx*MEM_ADDR_BITS +: MEM_ADDR_BITS] : '0;
  assign sram_if.byte_en    = g_any ? byte_en_i[g_idx*BW +: BW] : '0;
  assign sram_if.write_data = g_any ? write_data_i[g_idx*MEM_DATA_BITS +: MEM_DATA_BITS] : '0;
  assign sram_if.write_en   = g_any & g_we;
  assign sram_if.read_en    = g_any & ~g_we;

  assign rvalid_o = rd_v_q ? (N_PORTS'(1) << rd_port_q) : '0;
  assign rdata_o  = sram_if.read_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FREE;
      owner_q   <= '0;
      last_q    <= IW'(N_PORTS - 1);
      hold_q    <= '0;
      rd_port_q <= '0;
      rd_v_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      rd_port_q <= rd_port_d;
      rd_v_q    <= rd_v_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    rd_port_d = rd_port_q;
    rd_v_d    = 1'b0;
    if (g_any) begin
      last_d = g_idx;
      if (lock_i[g_idx]) begin
        state_d = OWNED;
        owner_d = g_idx;
        if (state_q == OWNED && owner_q == g_idx)
          hold_d = hold_max ? hold_q : hold_q + HW'(1);
        else
          hold_d = '0;
      end else begin
        state_d = FREE;
        hold_d  = '0;
      end
      if (!g_we) begin
        rd_v_d    = 1'b1;
        rd_port_d = g_idx;
      end
    end else begin
      state_d = FREE;
      hold_d  = '0;
    end
  end

endmodule

// File: tb/tb_generic_sram_byte_en_arbiter.sv
// Directed bench for generic_sram_byte_en_arbiter with a behavioural one-cycle SRAM.
module tb_generic_sram_byte_en_arbiter;

  localparam int unsigned NP = 2;
  localparam int unsigned AB = 10;
  localparam int unsigned DB = 32;

  logic            clk;
  logic            rst_n;
  logic [NP-1:0]   req, lock, we;
  logic [NP*AB-1:0] addr;
  logic [NP*4-1:0] be;
  logic [NP*DB-1:0] wd;
  logic [NP-1:0]   gnt, rvalid;
  logic [DB-1:0]   rdata;

  int n_tests = 0;
  int n_fail  = 0;

  generic_sram_byte_en_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) sram_bus ();

  generic_sram_byte_en_arbiter #(
    .N_PORTS(NP), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB), .MAX_HOLD(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .lock_i       (lock),
    .addr_i       (addr),
    .write_en_i   (we),
    .byte_en_i    (be),
    .write_data_i (wd),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .sram_if      (sram_bus)
  );

  // Behavioural SRAM: byte-masked writes, registered reads.
  logic [DB-1:0] mem [0:(1<<AB)-1];
  logic [DB-1:0] mem_rd;
  assign sram_bus.read_data = mem_rd;

  always @(posedge clk) begin
    if (sram_bus.write_en)
      for (int b = 0; b < 4; b++)
        if (sram_bus.byte_en[b]) mem[sram_bus.addr][8*b +: 8] <= sram_bus.write_data[8*b +: 8];
    if (sram_bus.read_en) mem_rd <= mem[sram_bus.addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; lock = '0; we = '0; addr = '0; be = '0; wd = '0;
  endtask

  task automatic drv(input int p, input logic r, input logic l, input logic w,
                     input logic [AB-1:0] a, input logic [3:0] b, input logic [DB-1:0] d);
    req[p] = r; lock[p] = l; we[p] = w;
    addr[p*AB +: AB] = a; be[p*4 +: 4] = b; wd[p*DB +: DB] = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Unlocked contention alternates, port 0 first.
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, 1, 10'h100, 4'hF, 32'h0);
      drv(1, 1, 0, 1, 10'h101, 4'hF, 32'h0);
      #1;
      chk($sformatf("rr_alt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    idle(); #1; chk("idle_gnt", 32'(gnt), 32'h0); tick();

    // Write by port 1, read back by port 0, then overwrite right after the read.
    idle(); drv(1, 1, 0, 1, 10'h010, 4'hF, 32'hDEADBEEF); #1;
    chk("wr1_gnt", 32'(gnt), 32'h2); tick();
    idle(); drv(0, 1, 0, 0, 10'h010, 4'hF, 32'h0); #1;
    chk("rd0_gnt", 32'(gnt), 32'h1);
    chk("wr_no_rvalid", 32'(rvalid), 32'h0); tick();
    idle(); drv(1, 1, 0, 1, 10'h010, 4'hF, 32'h12345678); #1;
    chk("rd0_rvalid", 32'(rvalid), 32'h1);
    chk("rd0_rdata_old", rdata, 32'hDEADBEEF);
    chk("war_gnt", 32'(gnt), 32'h2); tick();

    // Partial write over a full word.
    idle(); drv(0, 1, 0, 1, 10'h020, 4'hF, 32'h11223344); #1;
    chk("pw_full_gnt", 32'(gnt), 32'h1); tick();
    idle(); drv(0, 1, 0, 1, 10'h020, 4'h1, 32'h000000AA); #1;
    chk("pw_byte_gnt", 32'(gnt), 32'h1); tick();
    idle(); drv(0, 1, 0, 0, 10'h020, 4'hF, 32'h0); #1;
    chk("pw_rd_gnt", 32'(gnt), 32'h1); tick();
    idle(); #1;
    chk("pw_rvalid", 32'(rvalid), 32'h1);
    chk("pw_rdata", rdata, 32'h112233AA); tick();

    // Burst lock with MAX_HOLD=4 against a continuous competitor.
    idle(); drv(1, 1, 0, 1, 10'h101, 4'hF, 32'h0); #1;
    chk("lk_pre_gnt", 32'(gnt), 32'h2); tick();
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 1, 1, 10'h100, 4'hF, 32'h0);
      drv(1, 1, 0, 1, 10'h101, 4'hF, 32'h0);
      #1;
      chk($sformatf("lk_hold%0d", i), 32'(gnt), 32'h1);
      tick();
    end
    #1; chk("lk_rotate", 32'(gnt), 32'h2); tick();
    for (int i = 0; i < 6; i++) begin
      idle(); drv(0, 1, 1, 1, 10'h100, 4'hF, 32'h0);
      #1;
      chk($sformatf("lk_alone%0d", i), 32'(gnt), 32'h1);
      tick();
    end
    idle(); drv(1, 1, 0, 1, 10'h101, 4'hF, 32'h0); #1;
    chk("lk_handoff", 32'(gnt), 32'h2); tick();

    // Preload words 1..3.
    for (int i = 1; i <= 3; i++) begin
      idle(); drv(0, 1, 0, 1, AB'(i), 4'hF, 32'h000000A0 + 32'(i) * 32'h11 - 32'h11 + 32'h1); #1;
      chk($sformatf("pre_gnt%0d", i), 32'(gnt), 32'h1);
      tick();
    end

    // Reset in the cycle after a read grant drops the pending response.
    idle(); drv(0, 1, 0, 0, 10'h010, 4'hF, 32'h0); #1;
    chk("mr_gnt", 32'(gnt), 32'h1); tick();
    rst_n = 1'b0; idle(); #1;
    chk("mr_rvalid", 32'(rvalid), 32'h0);
    chk("mr_gnt_rst", 32'(gnt), 32'h0); tick();
    rst_n = 1'b1;

    // Interleaved reads 0,1,0 to addresses 1,2,3.
    idle(); drv(0, 1, 0, 0, 10'h001, 4'hF, 32'h0); drv(1, 1, 0, 0, 10'h002, 4'hF, 32'h0); #1;
    chk("il_gnt0", 32'(gnt), 32'h1); tick();
    idle(); drv(1, 1, 0, 0, 10'h002, 4'hF, 32'h0); #1;
    chk("il_gnt1", 32'(gnt), 32'h2);
    chk("il_rv0", 32'(rvalid), 32'h1);
    chk("il_rd0", rdata, 32'h000000A1); tick();
    idle(); drv(0, 1, 0, 0, 10'h003, 4'hF, 32'h0); #1;
    chk("il_gnt2", 32'(gnt), 32'h1);
    chk("il_rv1", 32'(rvalid), 32'h2);
    chk("il_rd1", rdata, 32'h000000B2); tick();
    idle(); #1;
    chk("il_gnt3", 32'(gnt), 32'h0);
    chk("il_rv2", 32'(rvalid), 32'h1);
    chk("il_rd2", rdata, 32'h000000C3); tick();
    idle(); #1;
    chk("il_rv_end", 32'(rvalid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
